// File: rtl/alu_pkg.sv
// Shared operation encodings for the move unit and the ALU decoder.
// Also provides the lane-count helper used to size lane-masked moves.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_MOV   = 2'd0,
      OP_MVN   = 2'd1,
      OP_CMOVZ = 2'd2,
      OP_MOVM  = 2'd3
   } op_e;

   // The top partial lane counts as a lane of its own.
   function automatic int num_lanes(input int width, input int lane);
      return (width + lane - 1) / lane;
   endfunction

endpackage

// File: rtl/move_lane_mux.sv
// Combinational per-lane select: the lane takes B when enabled, otherwise keeps A.
module move_lane_mux #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_lane,
   input  logic [W-1:0] b_lane,
   input  logic         sel,
   output logic [W-1:0] y_lane
);

   assign y_lane = sel ? b_lane : a_lane;

endmodule

// File: rtl/move.sv
// Registered move unit: MOV, MVN, conditional move on zero, and lane-masked move.
// One-cycle latency with Result, Zero and Moved held whenever In_valid is low.
module move
   import alu_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int LANE  = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [WIDTH-1:0]                   A,
   input  logic [WIDTH-1:0]                   B,
   input  logic [1:0]                         Op,
   input  logic [(WIDTH+LANE-1)/LANE-1:0]     Mask,
   input  logic                               In_valid,
   output logic [WIDTH-1:0]                   Result,
   output logic                               Out_valid,
   output logic                               Zero,
   output logic                               Moved
);

   localparam int NLANES = num_lanes(WIDTH, LANE);

   op_e              op;
   logic [WIDTH-1:0] movm_res;
   logic             a_is_zero;

   logic [WIDTH-1:0] result_d, result_q;
   logic             out_valid_d, out_valid_q;
   logic             zero_d, zero_q;
   logic             moved_d, moved_q;

   assign op        = op_e'(Op);
   assign a_is_zero = (A == '0);

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      localparam int LO = i * LANE;
      localparam int LW = (WIDTH - LO < LANE) ? (WIDTH - LO) : LANE;

      move_lane_mux #(
         .W(LW)
      ) u_lane_mux (
         .a_lane (A[LO +: LW]),
         .b_lane (B[LO +: LW]),
         .sel    (Mask[i]),
         .y_lane (movm_res[LO +: LW])
      );
   end

   // Zero is derived from the next Result so it always matches what is presented.
   always_comb begin
      result_d    = result_q;
      moved_d     = moved_q;
      out_valid_d = In_valid;
      if (In_valid) begin
         case (op)
            OP_MOV: begin
               result_d = B;
               moved_d  = 1'b1;
            end
            OP_MVN: begin
               result_d = ~B;
               moved_d  = 1'b1;
            end
            OP_CMOVZ: begin
               result_d = a_is_zero ? B : A;
               moved_d  = a_is_zero;
            end
            OP_MOVM: begin
               result_d = movm_res;
               moved_d  = |Mask;
            end
            default: begin
               result_d = result_q;
               moved_d  = moved_q;
            end
         endcase
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q    <= '0;
         out_valid_q <= 1'b0;
         zero_q      <= 1'b1;
         moved_q     <= 1'b0;
      end else begin
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         zero_q      <= zero_d;
         moved_q     <= moved_d;
      end
   end

   assign Result    = result_q;
   assign Out_valid = out_valid_q;
   assign Zero      = zero_q;
   assign Moved     = moved_q;

endmodule

// File: tb/tb_move.sv
// Self-checking bench for move: five instances of different WIDTH/LANE share one
// input bus (sliced per instance) and are compared against a bit-level reference model.
module tb_move;

   localparam int NI = 5;
   localparam int CFG_W [NI] = '{1, 8, 16, 13, 128};
   localparam int CFG_L [NI] = '{8, 8, 8, 4, 8};

   logic         clk;
   logic         rst_n;
   logic [127:0] tb_a;
   logic [127:0] tb_b;
   logic [1:0]   tb_op;
   logic [31:0]  tb_mask;
   logic         tb_valid;

   logic [0:0]   r1;
   logic [7:0]   r8;
   logic [15:0]  r16;
   logic [12:0]  r13;
   logic [127:0] r128;
   logic         ov [NI];
   logic         zr [NI];
   logic         mv [NI];
   logic [127:0] act_res [NI];

   logic [127:0] exp_res   [NI];
   logic         exp_zero  [NI];
   logic         exp_moved [NI];
   logic         exp_valid;

   int checks;
   int errors;

   move #(.WIDTH(1), .LANE(8)) d1 (
      .clk(clk), .rst_n(rst_n), .A(tb_a[0:0]), .B(tb_b[0:0]), .Op(tb_op),
      .Mask(tb_mask[0:0]), .In_valid(tb_valid), .Result(r1),
      .Out_valid(ov[0]), .Zero(zr[0]), .Moved(mv[0]));

   move #(.WIDTH(8), .LANE(8)) d8 (
      .clk(clk), .rst_n(rst_n), .A(tb_a[7:0]), .B(tb_b[7:0]), .Op(tb_op),
      .Mask(tb_mask[0:0]), .In_valid(tb_valid), .Result(r8),
      .Out_valid(ov[1]), .Zero(zr[1]), .Moved(mv[1]));

   move #(.WIDTH(16), .LANE(8)) d16 (
      .clk(clk), .rst_n(rst_n), .A(tb_a[15:0]), .B(tb_b[15:0]), .Op(tb_op),
      .Mask(tb_mask[1:0]), .In_valid(tb_valid), .Result(r16),
      .Out_valid(ov[2]), .Zero(zr[2]), .Moved(mv[2]));

   move #(.WIDTH(13), .LANE(4)) d13 (
      .clk(clk), .rst_n(rst_n), .A(tb_a[12:0]), .B(tb_b[12:0]), .Op(tb_op),
      .Mask(tb_mask[3:0]), .In_valid(tb_valid), .Result(r13),
      .Out_valid(ov[3]), .Zero(zr[3]), .Moved(mv[3]));

   move #(.WIDTH(128), .LANE(8)) d128 (
      .clk(clk), .rst_n(rst_n), .A(tb_a), .B(tb_b), .Op(tb_op),
      .Mask(tb_mask[15:0]), .In_valid(tb_valid), .Result(r128),
      .Out_valid(ov[4]), .Zero(zr[4]), .Moved(mv[4]));

   assign act_res[0] = 128'(r1);
   assign act_res[1] = 128'(r8);
   assign act_res[2] = 128'(r16);
   assign act_res[3] = 128'(r13);
   assign act_res[4] = r128;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bit-by-bit reference: each bit looks up its lane as j / lane.
   function automatic void ref_op(input int w, input int l, input logic [1:0] op,
                                  input logic [127:0] a_in, input logic [127:0] b_in,
                                  input logic [31:0] m, output logic [127:0] r,
                                  output logic moved);
      logic [127:0] a;
      logic [127:0] b;
      a = '0;
      b = '0;
      for (int j = 0; j < w; j++) begin
         a[j] = a_in[j];
         b[j] = b_in[j];
      end
      r = '0;
      moved = 1'b0;
      case (op)
         2'd0: begin r = b; moved = 1'b1; end
         2'd1: begin
            for (int j = 0; j < w; j++) r[j] = ~b[j];
            moved = 1'b1;
         end
         2'd2: begin
            if (a == 128'd0) begin r = b; moved = 1'b1; end
            else begin r = a; moved = 1'b0; end
         end
         default: begin
            for (int j = 0; j < w; j++) begin
               if (m[j / l]) begin r[j] = b[j]; moved = 1'b1; end
               else r[j] = a[j];
            end
         end
      endcase
   endfunction

   // Advance the model using the inputs presented now, then clock the DUTs.
   task automatic tick();
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            exp_res[k]   = '0;
            exp_zero[k]  = 1'b1;
            exp_moved[k] = 1'b0;
         end else if (tb_valid) begin
            ref_op(CFG_W[k], CFG_L[k], tb_op, tb_a, tb_b, tb_mask, exp_res[k], exp_moved[k]);
            exp_zero[k] = (exp_res[k] == 128'd0);
         end
      end
      exp_valid = rst_n & tb_valid;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tb_valid = 1'b1; tb_op = 2'd0; tb_b = '1; tb_a = '0; tb_mask = '0;
      tick();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (act_res[k] !== 128'd0 || ov[k] !== 1'b0 || zr[k] !== 1'b1 || mv[k] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset inst%0d got res=%h ov=%b z=%b mv=%b exp res=0 ov=0 z=1 mv=0",
                     k, act_res[k], ov[k], zr[k], mv[k]);
         end
      end
      rst_n = 1'b1; tb_b = 128'hFF;
      tick();
      checks++;
      if (r8 !== 8'hFF || ov[1] !== 1'b1 || zr[1] !== 1'b0 || mv[1] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL first_op got res=%h ov=%b z=%b mv=%b exp res=ff ov=1 z=0 mv=1",
                  r8, ov[1], zr[1], mv[1]);
      end
   endtask

   task automatic test_mov_w1();
      logic [1:0] pat [4];
      logic       want [4];
      pat  = '{2'b00, 2'b01, 2'b10, 2'b11};
      want = '{1'b0, 1'b1, 1'b0, 1'b1};
      tb_op = 2'd0; tb_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tb_a = 128'(pat[i][1]);
         tb_b = 128'(pat[i][0]);
         tick();
         checks++;
         if (r1[0] !== want[i] || ov[0] !== 1'b1 || zr[0] !== ~want[i]) begin
            errors++;
            $display("[TB] FAIL mov_w1 step%0d got res=%b ov=%b z=%b exp res=%b ov=1 z=%b",
                     i, r1[0], ov[0], zr[0], want[i], ~want[i]);
         end
      end
   endtask

   task automatic test_mvn_w128();
      tb_op = 2'd1; tb_b = '0; tb_a = 128'h5; tb_valid = 1'b1;
      tick();
      checks++;
      if (r128 !== {128{1'b1}} || zr[4] !== 1'b0 || mv[4] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mvn_w128 got res=%h z=%b mv=%b exp res=all-ones z=0 mv=1",
                  r128, zr[4], mv[4]);
      end
   endtask

   task automatic test_cmovz_w8();
      tb_op = 2'd2; tb_valid = 1'b1; tb_a = 128'h00; tb_b = 128'h5A;
      tick();
      checks++;
      if (r8 !== 8'h5A || mv[1] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cmovz_taken got res=%h mv=%b exp res=5a mv=1", r8, mv[1]);
      end
      tb_a = 128'h11;
      tick();
      checks++;
      if (r8 !== 8'h11 || mv[1] !== 1'b0 || zr[1] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL cmovz_kept got res=%h mv=%b z=%b exp res=11 mv=0 z=0", r8, mv[1], zr[1]);
      end
   endtask

   task automatic test_movm_w16();
      tb_op = 2'd3; tb_valid = 1'b1; tb_a = 128'h1234; tb_b = 128'hABCD; tb_mask = 32'h1;
      tick();
      checks++;
      if (r16 !== 16'h12CD || mv[2] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL movm_lane0 got res=%h mv=%b exp res=12cd mv=1", r16, mv[2]);
      end
      tb_mask = 32'h0;
      tick();
      checks++;
      if (r16 !== 16'h1234 || mv[2] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL movm_none got res=%h mv=%b exp res=1234 mv=0", r16, mv[2]);
      end
      tb_mask = 32'h2;
      tick();
      checks++;
      if (r16 !== 16'hAB34 || mv[2] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL movm_lane1 got res=%h mv=%b exp res=ab34 mv=1", r16, mv[2]);
      end
   endtask

   task automatic test_hold();
      tb_op = 2'd0; tb_valid = 1'b1; tb_b = 128'h5A;
      tick();
      tb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tb_op   = 2'($urandom_range(0, 3));
         tb_a    = {$urandom, $urandom, $urandom, $urandom};
         tb_b    = {$urandom, $urandom, $urandom, $urandom};
         tb_mask = $urandom;
         tick();
         checks++;
         if (r8 !== 8'h5A || ov[1] !== 1'b0 || zr[1] !== 1'b0 || mv[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold cyc%0d got res=%h ov=%b z=%b mv=%b exp res=5a ov=0 z=0 mv=1",
                     i, r8, ov[1], zr[1], mv[1]);
         end
      end
   endtask

   // Back-to-back random traffic on every instance, with occasional resets and idle cycles.
   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst_n    = ($urandom_range(0, 31) != 0);
         tb_valid = ($urandom_range(0, 4) != 0);
         tb_op    = 2'($urandom_range(0, 3));
         tb_b     = {$urandom, $urandom, $urandom, $urandom};
         tb_a     = ($urandom_range(0, 3) == 0) ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
         tb_mask  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         tick();
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (act_res[k] !== exp_res[k] || ov[k] !== exp_valid ||
                zr[k] !== exp_zero[k] || mv[k] !== exp_moved[k]) begin
               errors++;
               $display("[TB] FAIL random it%0d inst%0d got res=%h ov=%b z=%b mv=%b exp res=%h ov=%b z=%b mv=%b",
                        i, k, act_res[k], ov[k], zr[k], mv[k],
                        exp_res[k], exp_valid, exp_zero[k], exp_moved[k]);
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0; tb_a = '0; tb_b = '0; tb_op = 2'd0; tb_mask = '0; tb_valid = 1'b0;
      #1;
      test_reset();
      test_mov_w1();
      test_mvn_w128();
      test_cmovz_w8();
      test_movm_w16();
      test_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
